// File: rtl/to_local.sv
// Local ejection port: round-robin merge of E/W/N/S packets into a buffer feeding the local core.
// Latency: one cycle from acceptance into an empty buffer to local_valid.
// Backpressure: in_ready_* drops when the registered occupancy is full; local_ready never reaches in_ready_*.
// Optional feature: define TO_LOCAL_DROP_CHECK_EN to discard (and count) packets with nonzero dx/dy.

// Generic synchronous FIFO with registered occupancy and a resettable store.
// Latency: head_dat reflects a push into an empty FIFO after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module to_local_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != FULL_CNT);
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// Round-robin arbiter over four neighbour ports feeding the ejection FIFO.
// Latency: one cycle from in_ready_* transfer to local_valid on an empty buffer.
// Backpressure: grant withheld while registered fifo_count equals FIFO_DEPTH.
module to_local #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   in_packet_e,
    input  logic [15:0]                   in_packet_w,
    input  logic [15:0]                   in_packet_n,
    input  logic [15:0]                   in_packet_s,
    input  logic                          in_valid_e,
    input  logic                          in_valid_w,
    input  logic                          in_valid_n,
    input  logic                          in_valid_s,
    output logic                          in_ready_e,
    output logic                          in_ready_w,
    output logic                          in_ready_n,
    output logic                          in_ready_s,
    output logic [15:0]                   local_packet,
    output logic                          local_valid,
    input  logic                          local_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [3:0]  req_vld;
    logic [15:0] req_dat [4];
    logic [1:0]  prio_ptr;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic        gnt_vld;
    logic [15:0] gnt_dat;
    logic        acc_vld;
    logic [3:0]  rdy_vec;
    logic        push_vld;
    logic        pop_vld;

    assign req_vld    = {in_valid_s, in_valid_n, in_valid_w, in_valid_e};
    assign req_dat[0] = in_packet_e;
    assign req_dat[1] = in_packet_w;
    assign req_dat[2] = in_packet_n;
    assign req_dat[3] = in_packet_s;

    // First requester at or after prio_ptr, scanning in index order.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = prio_ptr;
        cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = prio_ptr + 2'(i);
            if (!gnt_vld && req_vld[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_dat = req_dat[gnt_idx];

    // rst_n gates the grant so no ready can be seen while reset is held.
    assign acc_vld = gnt_vld && (fifo_count != FULL_CNT) && rst_n;
    assign rdy_vec = acc_vld ? (4'b0001 << gnt_idx) : 4'b0000;

    assign in_ready_e = rdy_vec[0];
    assign in_ready_w = rdy_vec[1];
    assign in_ready_n = rdy_vec[2];
    assign in_ready_s = rdy_vec[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= 2'd0;
        end else if (acc_vld) begin
            prio_ptr <= gnt_idx + 2'd1;
        end
    end

`ifdef TO_LOCAL_DROP_CHECK_EN
    logic misroute;

    assign misroute = (gnt_dat[15:12] != 4'd0) || (gnt_dat[11:8] != 4'd0);
    assign push_vld = acc_vld && !misroute;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (acc_vld && misroute && (drop_cnt != 8'hff)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign push_vld = acc_vld;
    assign drop_cnt = 8'd0;
`endif

    assign local_valid = (fifo_count != '0);
    assign pop_vld     = local_valid && local_ready;

    to_local_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_vld),
        .push_dat (gnt_dat),
        .pop      (pop_vld),
        .head_dat (local_packet),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_to_local.sv
// Bench for to_local: vector table, directed corner sequences, and randomized traffic vs a queue model.
module tb_to_local;
    localparam int DEPTH = 4;
`ifdef TO_LOCAL_DROP_CHECK_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] pk [4];
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic        in_ready_e, in_ready_w, in_ready_n, in_ready_s;
    logic [15:0] local_packet;
    logic        local_valid;
    logic        local_ready;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    assign rdy = {in_ready_s, in_ready_n, in_ready_w, in_ready_e};

    to_local #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_packet_e  (pk[0]),
        .in_packet_w  (pk[1]),
        .in_packet_n  (pk[2]),
        .in_packet_s  (pk[3]),
        .in_valid_e   (vld[0]),
        .in_valid_w   (vld[1]),
        .in_valid_n   (vld[2]),
        .in_valid_s   (vld[3]),
        .in_ready_e   (in_ready_e),
        .in_ready_w   (in_ready_w),
        .in_ready_n   (in_ready_n),
        .in_ready_s   (in_ready_s),
        .local_packet (local_packet),
        .local_valid  (local_valid),
        .local_ready  (local_ready),
        .fifo_count   (fifo_count),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then move to the falling edge to sample.
    task automatic step(input logic [3:0] v, input logic lr);
        vld = v;
        local_ready = lr;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle with all valids high; everything must clear at once.
    task automatic do_reset(input string tag);
        vld = 4'b1111;
        local_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_rdy"}, rdy, 0);
        chk({tag, "_rst_lv"}, local_valid, 0);
        chk({tag, "_rst_cnt"}, fifo_count, 0);
        chk({tag, "_rst_pkt"}, local_packet, 16'h0000);
        chk({tag, "_rst_drop"}, drop_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_rst_hold_rdy"}, rdy, 0);
        vld = 4'b0000;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic        lr;
        logic [3:0]  e_rdy;
        logic        e_lv;
        logic [15:0] e_pkt;
        int          e_cnt;
    } vec_t;

    vec_t tbl [6];

    // Reference model state
    logic [15:0] mq [$];
    int          m_prio;
    int          m_drop;

    logic [15:0] outs [$];
    int          k;

    initial begin
        rst_n = 1'b1;
        vld = 4'b0000;
        local_ready = 1'b0;
        for (int i = 0; i < 4; i++) pk[i] = 16'h0000;
        #2;

        // ---- single packet into empty buffer ----
        do_reset("s1");
        pk[0] = 16'h0042;
        step(4'b0001, 1'b0);
        chk("s1_rdy", rdy, 4'b0001);
        chk("s1_lv0", local_valid, 0);
        adv();
        step(4'b0000, 1'b0);
        chk("s1_lv", local_valid, 1);
        chk("s1_pkt", local_packet, 16'h0042);
        chk("s1_cnt", fifo_count, 1);
        adv();
        step(4'b0000, 1'b1);
        chk("s1_hold_pkt", local_packet, 16'h0042);
        adv();
        step(4'b0000, 1'b0);
        chk("s1_empty", local_valid, 0);
        adv();

        // ---- round-robin table with all four requesting ----
        do_reset("rr");
        pk[0] = 16'h0001; pk[1] = 16'h0002; pk[2] = 16'h0003; pk[3] = 16'h0004;
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 16'h0000, 0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h0001, 1};
        tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'h0002, 1};
        tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'h0003, 1};
        tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 16'h0004, 1};
        tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].vld, tbl[i].lr);
            chk($sformatf("rr%0d_rdy", i), rdy, tbl[i].e_rdy);
            chk($sformatf("rr%0d_lv", i), local_valid, tbl[i].e_lv);
            chk($sformatf("rr%0d_cnt", i), fifo_count, tbl[i].e_cnt);
            if (tbl[i].e_lv) chk($sformatf("rr%0d_pkt", i), local_packet, tbl[i].e_pkt);
            adv();
        end

        // ---- fill to full with local_ready low, then drain ----
        do_reset("full");
        k = 0;
        for (int c = 0; c < 6; c++) begin
            pk[0] = 16'h0010 + 16'(k);
            step(4'b0001, 1'b0);
            if (rdy[0]) k++;
            adv();
        end
        chk("full_acc", k, 4);
        pk[0] = 16'h0010 + 16'(k);
        step(4'b0001, 1'b0);
        chk("full_cnt", fifo_count, 4);
        chk("full_rdy", rdy, 0);
        chk("full_head", local_packet, 16'h0010);
        adv();
        outs.delete();
        for (int c = 0; c < 16; c++) begin
            pk[0] = 16'h0010 + 16'(k);
            step((k < 6) ? 4'b0001 : 4'b0000, 1'b1);
            if (local_valid) outs.push_back(local_packet);
            if (rdy[0]) k++;
            adv();
        end
        chk("full_resume", k, 6);
        chk("full_nout", outs.size(), 6);
        for (int i = 0; i < outs.size() && i < 6; i++)
            chk($sformatf("full_out%0d", i), outs[i], 16'h0010 + 16'(i));

        // ---- simultaneous push and pop at count 2 ----
        do_reset("pp");
        pk[0] = 16'h00a1;
        step(4'b0001, 1'b0); adv();
        pk[0] = 16'h00a2;
        step(4'b0001, 1'b0); adv();
        pk[0] = 16'h00a3;
        step(4'b0001, 1'b1);
        chk("pp_cnt_before", fifo_count, 2);
        chk("pp_head_before", local_packet, 16'h00a1);
        chk("pp_rdy", rdy, 4'b0001);
        adv();
        step(4'b0000, 1'b0);
        chk("pp_cnt_after", fifo_count, 2);
        chk("pp_head_after", local_packet, 16'h00a2);
        pk[0] = 16'h00a4;
        adv();
        step(4'b0001, 1'b0); adv();
        step(4'b0000, 1'b0);
        chk("mid_cnt3", fifo_count, 3);
        adv();

        // ---- reset with three packets buffered ----
        do_reset("mid");
        for (int c = 0; c < 4; c++) begin
            step(4'b0000, 1'b1);
            chk($sformatf("mid_post%0d_lv", c), local_valid, 0);
            chk($sformatf("mid_post%0d_cnt", c), fifo_count, 0);
            adv();
        end

`ifdef TO_LOCAL_DROP_CHECK_EN
        // ---- misrouted packets are accepted, counted, not delivered ----
        do_reset("drop");
        pk[1] = 16'h1055;
        step(4'b0010, 1'b1);
        chk("drop_rdy", rdy, 4'b0010);
        adv();
        step(4'b0000, 1'b1);
        chk("drop_lv", local_valid, 0);
        chk("drop_cnt1", drop_cnt, 1);
        adv();
        for (int c = 0; c < 300; c++) begin
            step(4'b0010, 1'b1);
            adv();
        end
        step(4'b0000, 1'b1);
        chk("drop_sat", drop_cnt, 255);
        chk("drop_sat_lv", local_valid, 0);
        adv();
`endif

        // ---- randomized traffic against a queue model ----
        do_reset("rnd");
        begin
            logic [3:0]  cur_vld;
            logic [15:0] cur_pkt [4];
            int          prev_acc;
            int          g;
            bit          acc;
            bit          lr;
            logic [3:0]  e_rdy;
            mq.delete();
            m_prio = 0;
            m_drop = 0;
            prev_acc = -1;
            cur_vld = 4'b0000;
            for (int i = 0; i < 4; i++) cur_pkt[i] = 16'h0000;
            for (int c = 0; c < 3000; c++) begin
                // Senders hold until their packet transfers.
                for (int i = 0; i < 4; i++) begin
                    if (!cur_vld[i] || prev_acc == i) begin
                        cur_vld[i] = ($urandom_range(0, 99) < 55);
                        cur_pkt[i] = 16'($urandom);
                        if (DROP_EN && $urandom_range(0, 1) == 0) cur_pkt[i][15:8] = 8'h00;
                    end
                    pk[i] = cur_pkt[i];
                end
                lr = ($urandom_range(0, 99) < 45);
                g = -1;
                for (int j = 0; j < 4; j++) begin
                    if (g < 0 && cur_vld[(m_prio + j) % 4]) g = (m_prio + j) % 4;
                end
                acc = (g >= 0) && (mq.size() < DEPTH);
                e_rdy = acc ? (4'b0001 << g) : 4'b0000;
                step(cur_vld, lr);
                chk("rnd_rdy", rdy, e_rdy);
                chk("rnd_lv", local_valid, (mq.size() != 0));
                chk("rnd_cnt", fifo_count, mq.size());
                chk("rnd_drop", drop_cnt, m_drop);
                if (mq.size() != 0) chk("rnd_pkt", local_packet, mq[0]);
                if (lr && mq.size() != 0) void'(mq.pop_front());
                if (acc) begin
                    m_prio = (g + 1) % 4;
                    if (DROP_EN && cur_pkt[g][15:8] != 8'h00) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        mq.push_back(cur_pkt[g]);
                    end
                end
                prev_acc = acc ? g : -1;
                adv();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/to_local.md
TO_LOCAL -- requirements
Module: to_local

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning ejection buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_packet_e/w/n/s  input  16 each  packets arriving from east/west/north/south neighbours; [15:12] dx signed, [11:8] dy signed, [7:0] payload.
REQ-005 SHALL have ports in_valid_e/w/n/s  input  1 each  packet on the matching port is valid.
REQ-006 SHALL have ports in_ready_e/w/n/s  output  1 each  matching port's packet is accepted this cycle.
REQ-007 SHALL have port local_packet  output  16  head-of-buffer packet to the local core.
REQ-008 SHALL have port local_valid  output  1  local_packet holds valid data.
REQ-009 SHALL have port local_ready  input  1  local core accepts local_packet this cycle.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-011 SHALL have port drop_cnt  output  8  count of discarded misrouted packets.

Function
REQ-012 SHALL define a transfer on any port as valid AND ready high at a rising clk edge; senders hold packet/valid stable until transfer.
REQ-013 SHALL arbitrate round-robin over requesters in index order E=0, W=1, N=2, S=3, starting from the priority pointer; at most one in_ready_* high per cycle.
REQ-014 SHALL assert in_ready_* only for the granted port and only when fifo_count < FIFO_DEPTH (registered count; no combinational path from local_ready to in_ready_*).
REQ-015 SHALL set priority pointer to (granted index + 1) mod 4 after each transfer; pointer unchanged in cycles with no transfer.
REQ-016 SHALL write each accepted packet unmodified into the buffer tail; order of acceptance is preserved at the output.
REQ-017 SHALL drive local_valid = (fifo_count != 0) and local_packet = buffer head, both from registered state.
REQ-018 SHALL pop the head when local_valid AND local_ready at a rising edge.
REQ-019 SHALL give latency of one cycle: a packet accepted at edge N into an empty buffer is on local_packet with local_valid high after edge N.
REQ-020 SHALL keep fifo_count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-021 SHALL never push when full and never pop when empty; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL keep local_packet stable while local_valid is high and local_ready is low.

Reset
REQ-023 SHALL, while rst_n low, immediately force fifo_count=0, read/write pointers=0, priority pointer=0 (E), drop_cnt=0, local_valid=0, local_packet=16'h0000, all in_ready_*=0.
REQ-024 SHALL discard all buffered packets on reset asserted mid-operation; no partial transfer survives reset.
REQ-025 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro TO_LOCAL_DROP_CHECK_EN.
REQ-027 SHALL, with TO_LOCAL_DROP_CHECK_EN defined, accept (ready high per REQ-014) but not buffer any granted packet with dx != 0 or dy != 0, increment drop_cnt saturating at 255, and still advance the priority pointer.
REQ-028 SHALL, without TO_LOCAL_DROP_CHECK_EN, buffer every accepted packet regardless of dx/dy and tie drop_cnt to 0.

Verification
REQ-029 SHALL cover: after reset, in_valid_e=1 with 16'h0042 into empty buffer -> in_ready_e=1 that cycle; next cycle local_valid=1, local_packet=16'h0042, fifo_count=1.
REQ-030 SHALL cover: all four valids held high with packets 16'h0001/02/03/04 (E/W/N/S), local_ready=1 -> grants E,W,N,S in consecutive cycles; output order 0001,0002,0003,0004.
REQ-031 SHALL cover: local_ready=0, E streams 6 packets, FIFO_DEPTH=4 -> 4 accepted, fifo_count=4, in_ready_e=0 afterwards; raising local_ready drains in order and resumes acceptance.
REQ-032 SHALL cover: fifo_count=2 with simultaneous push and pop -> fifo_count stays 2, head advances by one.
REQ-033 SHALL cover (TO_LOCAL_DROP_CHECK_EN defined): in_packet_w=16'h1055 accepted -> not output, drop_cnt=1; 300 such packets -> drop_cnt=255.
REQ-034 SHALL cover: rst_n pulsed low with fifo_count=3 -> local_valid=0 and fifo_count=0 immediately, no stale packet emitted after release.
